// File: rtl/pa_ctrl_pkg.sv
// Shared control-word layout, forwarding codes and sequencer states.
package pa_ctrl_pkg;

  localparam int unsigned CW_DEFAULT_W = 21;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned FWD_W        = 2;

  // Control word bit offsets, LSB first:
  // {SRD[2],PSW_LE_RE[2],B,SOH_OP[3],ALU_OP[4],RAM_CTRL[4],L,RF_LE,ID_SR[2],UB}
  localparam int unsigned CW_UB        = 0;
  localparam int unsigned CW_ID_SR_LO  = 1;
  localparam int unsigned CW_RF_LE     = 3;
  localparam int unsigned CW_L         = 4;
  localparam int unsigned CW_RAM_LO    = 5;
  localparam int unsigned CW_RAM_W     = 4;
  localparam int unsigned CW_ALU_LO    = 9;
  localparam int unsigned CW_ALU_W     = 4;
  localparam int unsigned CW_SOH_LO    = 13;
  localparam int unsigned CW_SOH_W     = 3;
  localparam int unsigned CW_B         = 16;
  localparam int unsigned CW_PSW_LO    = 17;
  localparam int unsigned CW_SRD_LO    = 19;

  // RAM_CTRL and ID_SR sub-field bit indices
  localparam int unsigned RAM_E        = 0;
  localparam int unsigned RAM_WB       = 1;
  localparam int unsigned CW_RAM_E     = CW_RAM_LO + RAM_E;
  localparam int unsigned CW_RAM_WB    = CW_RAM_LO + RAM_WB;
  localparam int unsigned CW_USE_RA    = CW_ID_SR_LO + 0;
  localparam int unsigned CW_USE_RB    = CW_ID_SR_LO + 1;

  // Operand source encodings
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  // Sequencer state codes
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    FAULT    = ST_FAULT
  } seq_state_t;

  localparam logic [CW_DEFAULT_W-1:0] CW_NOP = '0;

endpackage

// File: rtl/operand_fwd_sel.sv
// Picks the forwarding source for one ID operand and flags a load-use hit.
module operand_fwd_sel
  import pa_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rf_le,
  input  logic             ex_l,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_rf_le,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_rf_le,
  output logic [FWD_W-1:0] fwd,
  output logic             load_use
);

  // Youngest matching writer wins; r0 never matches; a load in EX stalls instead of forwarding
  always_comb begin
    fwd      = FWD_RF;
    load_use = 1'b0;
    if (use_src && (src != '0)) begin
      if (ex_rf_le && (ex_rd == src)) begin
        if (ex_l) begin
          load_use = 1'b1;
        end else begin
          fwd = FWD_EX;
        end
      end else if (mem_rf_le && (mem_rd == src)) begin
        fwd = FWD_MEM;
      end else if (wb_rf_le && (wb_rd == src)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Moves the decoded control word through EX/MEM/WB, handling hazards,
// branch redirect and RAM wait/timeout.
module pipe_ctrl_sequencer
  import pa_ctrl_pkg::*;
#(
  parameter int unsigned CW_W     = 21,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW_W-1:0]  id_cw,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_cond_true,
  input  logic             mem_ack,
  output logic [CW_W-1:0]  ex_cw,
  output logic [CW_W-1:0]  mem_cw,
  output logic [CW_W-1:0]  wb_cw,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             if_squash,
  output logic             pc_sel_target,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             mem_req,
  output logic             mem_timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW_W-1:0]  ex_cw_d, mem_cw_d, wb_cw_d;
  logic [REG_W-1:0] ex_rd_d, mem_rd_d, wb_rd_d;

  logic freeze;
  logic taken;
  logic hit_a, hit_b;
  logic load_use;

  assign mem_req     = mem_cw[CW_RAM_E] & (state_q != FAULT);
  assign freeze      = mem_req & ~mem_ack;
  assign taken       = ex_cw[CW_B] & (ex_cw[CW_UB] | ex_cond_true);
  assign load_use    = hit_a | hit_b;
  assign mem_timeout = (state_q == FAULT);

  operand_fwd_sel u_fwd_a (
    .src       (id_ra),
    .use_src   (id_cw[CW_USE_RA]),
    .ex_rd     (ex_rd),
    .ex_rf_le  (ex_cw[CW_RF_LE]),
    .ex_l      (ex_cw[CW_L]),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_cw[CW_RF_LE]),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_cw[CW_RF_LE]),
    .fwd       (fwd_a),
    .load_use  (hit_a)
  );

  operand_fwd_sel u_fwd_b (
    .src       (id_rb),
    .use_src   (id_cw[CW_USE_RB]),
    .ex_rd     (ex_rd),
    .ex_rf_le  (ex_cw[CW_RF_LE]),
    .ex_l      (ex_cw[CW_L]),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_cw[CW_RF_LE]),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_cw[CW_RF_LE]),
    .fwd       (fwd_b),
    .load_use  (hit_b)
  );

  // State, wait counter and stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      ex_cw      <= '0;
      mem_cw     <= '0;
      wb_cw      <= '0;
      ex_rd      <= '0;
      mem_rd     <= '0;
      wb_rd      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ex_cw      <= ex_cw_d;
      mem_cw     <= mem_cw_d;
      wb_cw      <= wb_cw_d;
      ex_rd      <= ex_rd_d;
      mem_rd     <= mem_rd_d;
      wb_rd      <= wb_rd_d;
    end
  end

  // Next state, stage movement and fetch control; freeze > taken branch > load-use
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    ex_cw_d       = ex_cw;
    mem_cw_d      = mem_cw;
    wb_cw_d       = wb_cw;
    ex_rd_d       = ex_rd;
    mem_rd_d      = mem_rd;
    wb_rd_d       = wb_rd;
    pc_le         = 1'b1;
    ifid_le       = 1'b1;
    if_squash     = 1'b0;
    pc_sel_target = 1'b0;

    if (state_q == FAULT) begin
      // Fetch stopped; remaining work drains out through WB
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      ex_cw_d  = '0;
      ex_rd_d  = '0;
      mem_cw_d = '0;
      mem_rd_d = '0;
      wb_cw_d  = mem_cw;
      wb_rd_d  = mem_rd;
    end else if (freeze) begin
      // Hold EX/MEM; WB gets a bubble so nothing retires twice
      pc_le   = 1'b0;
      ifid_le = 1'b0;
      wb_cw_d = '0;
      wb_rd_d = '0;
      if (state_q == RUN) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = CNT_W'(1);
      end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
        state_d = FAULT;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      ex_cw_d    = id_cw;
      ex_rd_d    = id_rd;
      mem_cw_d   = ex_cw;
      mem_rd_d   = ex_rd;
      wb_cw_d    = mem_cw;
      wb_rd_d    = mem_rd;
      if (taken) begin
        pc_sel_target = 1'b1;
        if_squash     = 1'b1;
      end else if (load_use) begin
        pc_le   = 1'b0;
        ifid_le = 1'b0;
        ex_cw_d = '0;
        ex_rd_d = '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Directed scoreboard bench for pipe_ctrl_sequencer (MAX_WAIT = 4).
module tb_pipe_ctrl_sequencer;

  localparam int unsigned CW_W = 21;

  // Hand-encoded control words
  localparam logic [CW_W-1:0] NOP = 21'h00000;
  localparam logic [CW_W-1:0] ADD = 21'h0020E;  // RF_LE, uses ra+rb
  localparam logic [CW_W-1:0] LDW = 21'h0023A;  // RF_LE, L, E, uses ra
  localparam logic [CW_W-1:0] STW = 21'h00266;  // E, write, uses ra+rb
  localparam logic [CW_W-1:0] BL  = 21'h10009;  // B, UB, RF_LE
  localparam logic [CW_W-1:0] BC  = 21'h10000;  // conditional branch

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CW_W-1:0] id_cw = '0;
  logic [4:0]      id_ra = '0, id_rb = '0, id_rd = '0;
  logic            ex_cond_true = 1'b0;
  logic            mem_ack = 1'b0;
  logic [CW_W-1:0] ex_cw, mem_cw, wb_cw;
  logic [4:0]      ex_rd, mem_rd, wb_rd;
  logic            pc_le, ifid_le, if_squash, pc_sel_target;
  logic [1:0]      fwd_a, fwd_b;
  logic            mem_req, mem_timeout;

  always #5 clk = ~clk;

  pipe_ctrl_sequencer #(.CW_W(CW_W), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_cw(id_cw), .id_ra(id_ra), .id_rb(id_rb),
    .id_rd(id_rd), .ex_cond_true(ex_cond_true), .mem_ack(mem_ack),
    .ex_cw(ex_cw), .mem_cw(mem_cw), .wb_cw(wb_cw),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .pc_le(pc_le), .ifid_le(ifid_le), .if_squash(if_squash),
    .pc_sel_target(pc_sel_target), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_req(mem_req), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic [CW_W-1:0] ex_cw;
    logic [CW_W-1:0] mem_cw;
    logic [CW_W-1:0] wb_cw;
    logic [4:0]      ex_rd;
    logic [4:0]      mem_rd;
    logic [4:0]      wb_rd;
    logic            pc_le;
    logic            ifid_le;
    logic            if_squash;
    logic            pc_sel_target;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            mem_req;
    logic            mem_timeout;
  } obs_t;

  typedef struct {
    string name;
    obs_t  val;
    obs_t  care;
  } exp_t;

  obs_t obs;
  assign obs = {ex_cw, mem_cw, wb_cw, ex_rd, mem_rd, wb_rd, pc_le, ifid_le,
                if_squash, pc_sel_target, fwd_a, fwd_b, mem_req, mem_timeout};

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Monitor: one scoreboard entry per cycle, compared mid-cycle on the falling edge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.care != '0) begin
        checks++;
        if (((obs ^ mon_e.val) & mon_e.care) != '0) begin
          failures++;
          $display("FAIL %s: got=%h want=%h care=%h", mon_e.name,
                   obs & mon_e.care, mon_e.val, mon_e.care);
        end
      end
    end
  end

  function automatic exp_t mk(input string n);
    exp_t e;
    e.name = n;
    e.val  = '0;
    e.care = '0;
    return e;
  endfunction

  function automatic void c_ctrl(inout exp_t e, input logic pc, input logic ifid,
                                 input logic sq, input logic sel);
    e.val.pc_le = pc;          e.care.pc_le = 1'b1;
    e.val.ifid_le = ifid;      e.care.ifid_le = 1'b1;
    e.val.if_squash = sq;      e.care.if_squash = 1'b1;
    e.val.pc_sel_target = sel; e.care.pc_sel_target = 1'b1;
  endfunction

  function automatic void c_fwd(inout exp_t e, input logic [1:0] a, input logic [1:0] b);
    e.val.fwd_a = a; e.care.fwd_a = '1;
    e.val.fwd_b = b; e.care.fwd_b = '1;
  endfunction

  function automatic void c_mem(inout exp_t e, input logic req, input logic tmo);
    e.val.mem_req = req;     e.care.mem_req = 1'b1;
    e.val.mem_timeout = tmo; e.care.mem_timeout = 1'b1;
  endfunction

  function automatic void c_ex(inout exp_t e, input logic [CW_W-1:0] cw, input logic [4:0] rd);
    e.val.ex_cw = cw; e.care.ex_cw = '1;
    e.val.ex_rd = rd; e.care.ex_rd = '1;
  endfunction

  function automatic void c_ms(inout exp_t e, input logic [CW_W-1:0] cw, input logic [4:0] rd);
    e.val.mem_cw = cw; e.care.mem_cw = '1;
    e.val.mem_rd = rd; e.care.mem_rd = '1;
  endfunction

  function automatic void c_wb(inout exp_t e, input logic [CW_W-1:0] cw, input logic [4:0] rd);
    e.val.wb_cw = cw; e.care.wb_cw = '1;
    e.val.wb_rd = rd; e.care.wb_rd = '1;
  endfunction

  function automatic exp_t reset_exp(input string n);
    exp_t e;
    e = mk(n);
    c_ex(e, NOP, 5'd0);
    c_ms(e, NOP, 5'd0);
    c_wb(e, NOP, 5'd0);
    c_ctrl(e, 1'b1, 1'b1, 1'b0, 1'b0);
    c_fwd(e, 2'b00, 2'b00);
    c_mem(e, 1'b0, 1'b0);
    return e;
  endfunction

  task automatic drv(input logic [CW_W-1:0] cw, input logic [4:0] ra,
                     input logic [4:0] rb, input logic [4:0] rd);
    id_cw = cw; id_ra = ra; id_rb = rb; id_rd = rd;
  endtask

  // Queue this cycle's expectation, then move to just after the next rising edge
  task automatic step(input exp_t e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk("idle"));
  endtask

  exp_t e;

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    step(reset_exp("reset_init"));
    rst_n = 1'b1;

    // 1: ALU result forwarding EX > MEM > WB
    drv(ADD, 5'd1, 5'd2, 5'd3);  idle(1);
    drv(ADD, 5'd3, 5'd7, 5'd4);
    e = mk("t1_fwd_ex"); c_fwd(e, 2'b01, 2'b00); c_ctrl(e, 1, 1, 0, 0); c_ex(e, ADD, 5'd3); step(e);
    drv(ADD, 5'd3, 5'd4, 5'd6);
    e = mk("t1_fwd_mem_ex"); c_fwd(e, 2'b10, 2'b01); c_ex(e, ADD, 5'd4); c_ms(e, ADD, 5'd3); step(e);
    drv(ADD, 5'd3, 5'd3, 5'd9);
    e = mk("t1_fwd_wb"); c_fwd(e, 2'b11, 2'b11); c_wb(e, ADD, 5'd3); c_ctrl(e, 1, 1, 0, 0); step(e);

    // 2: load-use bubble, then MEM forward with a zero-wait access
    drv(LDW, 5'd1, 5'd0, 5'd5);  idle(1);
    drv(ADD, 5'd2, 5'd5, 5'd8);
    e = mk("t2_stall"); c_ctrl(e, 0, 0, 0, 0); c_ex(e, LDW, 5'd5); c_mem(e, 0, 0); step(e);
    mem_ack = 1'b1;
    e = mk("t2_bubble_fwd"); c_ex(e, NOP, 5'd0); c_ms(e, LDW, 5'd5); c_fwd(e, 2'b00, 2'b10);
    c_ctrl(e, 1, 1, 0, 0); c_mem(e, 1, 0); step(e);
    mem_ack = 1'b0;
    drv(NOP, 5'd0, 5'd0, 5'd0);
    e = mk("t2_after"); c_ex(e, ADD, 5'd8); c_wb(e, LDW, 5'd5); c_mem(e, 0, 0); step(e);

    // 3: unconditional branch with delay slot, then conditional not-taken/taken
    drv(BL, 5'd0, 5'd0, 5'd31);  idle(1);
    drv(ADD, 5'd1, 5'd2, 5'd10);
    e = mk("t3_bl_taken"); c_ctrl(e, 1, 1, 1, 1); c_ex(e, BL, 5'd31); step(e);
    drv(NOP, 5'd0, 5'd0, 5'd0);
    e = mk("t3_delay_slot"); c_ctrl(e, 1, 1, 0, 0); c_ex(e, ADD, 5'd10); step(e);
    drv(BC, 5'd0, 5'd0, 5'd0);   idle(1);
    e = mk("t3_bc_not_taken"); c_ctrl(e, 1, 1, 0, 0); c_ex(e, BC, 5'd0); step(e);
    drv(NOP, 5'd0, 5'd0, 5'd0);
    ex_cond_true = 1'b1;
    e = mk("t3_bc_taken"); c_ctrl(e, 1, 1, 1, 1); step(e);
    ex_cond_true = 1'b0;
    idle(3);

    // 4: store waits two cycles, acked on the third
    drv(ADD, 5'd1, 5'd2, 5'd13); idle(1);
    drv(STW, 5'd1, 5'd2, 5'd0);  idle(1);
    drv(ADD, 5'd1, 5'd2, 5'd11); idle(1);
    drv(ADD, 5'd1, 5'd2, 5'd12);
    e = mk("t4_wait1"); c_mem(e, 1, 0); c_ctrl(e, 0, 0, 0, 0); c_ms(e, STW, 5'd0);
    c_wb(e, ADD, 5'd13); step(e);
    e = mk("t4_wait2"); c_mem(e, 1, 0); c_ctrl(e, 0, 0, 0, 0); c_ex(e, ADD, 5'd11);
    c_ms(e, STW, 5'd0); c_wb(e, NOP, 5'd0); step(e);
    mem_ack = 1'b1;
    e = mk("t4_ack"); c_mem(e, 1, 0); c_ctrl(e, 1, 1, 0, 0); c_wb(e, NOP, 5'd0); step(e);
    mem_ack = 1'b0;
    drv(NOP, 5'd0, 5'd0, 5'd0);
    e = mk("t4_advanced"); c_ex(e, ADD, 5'd12); c_ms(e, ADD, 5'd11); c_wb(e, STW, 5'd0);
    c_mem(e, 0, 0); c_ctrl(e, 1, 1, 0, 0); step(e);
    idle(3);

    // 5: load never acked -> timeout fault after four wait cycles
    drv(LDW, 5'd1, 5'd0, 5'd7);  idle(1);
    drv(ADD, 5'd1, 5'd2, 5'd14); idle(1);
    drv(NOP, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      e = mk($sformatf("t5_wait%0d", i)); c_mem(e, 1, 0); c_ctrl(e, 0, 0, 0, 0); step(e);
    end
    e = mk("t5_fault"); c_mem(e, 0, 1); c_ctrl(e, 0, 0, 0, 0); c_ex(e, ADD, 5'd14);
    c_ms(e, LDW, 5'd7); step(e);
    e = mk("t5_drain"); c_mem(e, 0, 1); c_ctrl(e, 0, 0, 0, 0); c_ex(e, NOP, 5'd0);
    c_ms(e, NOP, 5'd0); c_wb(e, LDW, 5'd7); step(e);
    mem_ack = 1'b1;
    e = mk("t5_sticky"); c_mem(e, 0, 1); c_ctrl(e, 0, 0, 0, 0); c_wb(e, NOP, 5'd0); step(e);
    mem_ack = 1'b0;
    e = mk("t5_sticky2"); c_mem(e, 0, 1); c_ctrl(e, 0, 0, 0, 0); step(e);
    rst_n = 1'b0;
    step(reset_exp("t5_reset_clears"));
    rst_n = 1'b1;

    // 6: async reset mid-wait, then r0 never forwards or stalls
    drv(STW, 5'd1, 5'd2, 5'd0);  idle(1);
    drv(ADD, 5'd1, 5'd2, 5'd15); idle(1);
    e = mk("t6_wait_a"); c_mem(e, 1, 0); c_ctrl(e, 0, 0, 0, 0); step(e);
    e = mk("t6_wait_b"); c_mem(e, 1, 0); c_ctrl(e, 0, 0, 0, 0); c_ms(e, STW, 5'd0); step(e);
    rst_n = 1'b0;
    step(reset_exp("t6_async_reset"));
    rst_n = 1'b1;
    drv(ADD, 5'd1, 5'd2, 5'd0);  idle(1);
    drv(LDW, 5'd0, 5'd0, 5'd0);
    e = mk("t6_r0_ex_writer"); c_fwd(e, 2'b00, 2'b00); c_ctrl(e, 1, 1, 0, 0); c_ex(e, ADD, 5'd0); step(e);
    drv(ADD, 5'd0, 5'd0, 5'd16);
    e = mk("t6_r0_load"); c_fwd(e, 2'b00, 2'b00); c_ctrl(e, 1, 1, 0, 0); c_ex(e, LDW, 5'd0); step(e);
    drv(NOP, 5'd0, 5'd0, 5'd0);
    mem_ack = 1'b1;
    e = mk("t6_no_bubble"); c_ex(e, ADD, 5'd16); c_mem(e, 1, 0); c_ctrl(e, 1, 1, 0, 0); step(e);
    mem_ack = 1'b0;
    idle(2);

    // Let the monitor empty the scoreboard, bounded
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
